// File: rtl/cache_ctrl_fsm_if.sv
// cache_ctrl_fsm_if: CPU-side and memory-side handshake bundle for the cache controller.
// The slave modport is the controller; the master modport is the CPU/memory environment.
interface cache_ctrl_fsm_if #(
  parameter int ADDR_W = 10,
  parameter int LINE_W = 128
);
  logic              cpu_req;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              cpu_hit;

  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_hit,
    output mem_req, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_hit,
    input  mem_req, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: write-back, write-allocate direct-mapped cache controller with registered
// CPU/memory handshakes. Define CACHE_CTRL_STATS_EN to add saturating hit/miss counters.
module cache_ctrl_fsm #(
  parameter int ADDR_W    = 10,
  parameter int NUM_LINES = 2,
  parameter int LINE_W    = 128
) (
  input  logic            clk,
  input  logic            reset,
  cache_ctrl_fsm_if.slave bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]     o_hit_cnt,
  output logic [15:0]     o_miss_cnt
`endif
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t r_state, w_stateNext;

  logic              r_rw;
  logic [ADDR_W-1:2] r_addr;
  logic [31:0]       r_wdata;
  logic              r_miss;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  logic              r_cpuReady, w_cpuReadyNext;
  logic [31:0]       r_cpuRdata, w_cpuRdataNext;
  logic              r_cpuHit,   w_cpuHitNext;
  logic              r_memReq,   w_memReqNext;
  logic              r_memRw,    w_memRwNext;
  logic [ADDR_W-1:0] r_memAddr,  w_memAddrNext;
  logic [LINE_W-1:0] r_memWdata, w_memWdataNext;

  logic              w_latch;
  logic              w_missNext;
  logic              w_wrHit;
  logic              w_refill;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [6:0]        w_wordBit;
  logic [LINE_W-1:0] w_line;
  logic [31:0]       w_word;

  assign w_idx     = r_addr[4 +: IDX_W];
  assign w_tag     = r_addr[ADDR_W-1 -: TAG_W];
  assign w_wordBit = {r_addr[3:2], 5'b0};
  assign w_line    = r_data[w_idx];
  assign w_word    = w_line[w_wordBit +: 32];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  // A refilled line goes back through COMPARE so hits and misses share one completion path.
  always_comb begin
    w_stateNext    = r_state;
    w_cpuReadyNext = 1'b0;
    w_cpuRdataNext = r_cpuRdata;
    w_cpuHitNext   = r_cpuHit;
    w_memReqNext   = r_memReq;
    w_memRwNext    = r_memRw;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_latch        = 1'b0;
    w_missNext     = r_miss;
    w_wrHit        = 1'b0;
    w_refill       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) begin
          w_latch     = 1'b1;
          w_missNext  = 1'b0;
          w_stateNext = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_cpuReadyNext = 1'b1;
          w_cpuHitNext   = ~r_miss;
          if (r_rw) w_wrHit = 1'b1;
          else      w_cpuRdataNext = w_word;
          w_stateNext = S_IDLE;
        end else begin
          w_missNext   = 1'b1;
          w_memReqNext = 1'b1;
          if (r_valid[w_idx] && r_dirty[w_idx]) begin
            w_memRwNext    = 1'b1;
            w_memAddrNext  = {r_tag[w_idx], w_idx, 4'b0};
            w_memWdataNext = w_line;
            w_stateNext    = S_WRITEBACK;
          end else begin
            w_memRwNext   = 1'b0;
            w_memAddrNext = {w_tag, w_idx, 4'b0};
            w_stateNext   = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (r_memReq && bus.mem_ready) begin
          w_memReqNext = 1'b0;
          w_stateNext  = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (!r_memReq) begin
          w_memReqNext  = 1'b1;
          w_memRwNext   = 1'b0;
          w_memAddrNext = {w_tag, w_idx, 4'b0};
        end else if (bus.mem_ready) begin
          w_refill     = 1'b1;
          w_memReqNext = 1'b0;
          w_stateNext  = S_COMPARE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_miss     <= 1'b0;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_cpuReady <= 1'b0;
      r_cpuRdata <= '0;
      r_cpuHit   <= 1'b0;
      r_memReq   <= 1'b0;
      r_memRw    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
    end else begin
      if (w_latch) begin
        r_rw    <= bus.cpu_rw;
        r_addr  <= bus.cpu_addr[ADDR_W-1:2];
        r_wdata <= bus.cpu_wdata;
      end
      r_miss     <= w_missNext;
      r_cpuReady <= w_cpuReadyNext;
      r_cpuRdata <= w_cpuRdataNext;
      r_cpuHit   <= w_cpuHitNext;
      r_memReq   <= w_memReqNext;
      r_memRw    <= w_memRwNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
      if (w_refill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wrHit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (w_refill) begin
      r_data[w_idx] <= bus.mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wrHit) begin
      r_data[w_idx][w_wordBit +: 32] <= r_wdata;
    end
  end

  assign bus.cpu_ready = r_cpuReady;
  assign bus.cpu_rdata = r_cpuRdata;
  assign bus.cpu_hit   = r_cpuHit;
  assign bus.mem_req   = r_memReq;
  assign bus.mem_rw    = r_memRw;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] r_hitCnt;
  logic [15:0] r_missCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else if (w_cpuReadyNext) begin
      if (w_cpuHitNext && (r_hitCnt != 16'hFFFF))    r_hitCnt  <= r_hitCnt + 16'd1;
      if (!w_cpuHitNext && (r_missCnt != 16'hFFFF))  r_missCnt <= r_missCnt + 16'd1;
    end
  end

  assign o_hit_cnt  = r_hitCnt;
  assign o_miss_cnt = r_missCnt;
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed self-checking bench with CPU and memory scoreboards for
// cache_ctrl_fsm; checks the hit/miss counters when CACHE_CTRL_STATS_EN is defined.
module tb_cache_ctrl_fsm;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    int          cycles;
  } cpuExp_t;

  typedef struct {
    logic         rw;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } memExp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   memWait;
  int   memWaitLeft;
  bit   memEnable;

  cpuExp_t      cpuQ[$];
  memExp_t      memQ[$];
  logic [127:0] memArr [64];

  cache_ctrl_fsm_if #(.ADDR_W(10), .LINE_W(128)) bus ();

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hitCnt;
  logic [15:0] missCnt;
`endif

  cache_ctrl_fsm #(.ADDR_W(10), .NUM_LINES(2), .LINE_W(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .o_hit_cnt  (hitCnt),
    .o_miss_cnt (missCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pushMem(input logic rw, input logic [9:0] addr, input logic [127:0] wdata);
    memExp_t e;
    e.rw    = rw;
    e.addr  = addr;
    e.wdata = wdata;
    memQ.push_back(e);
  endtask

  // Issue one CPU access, then wait (bounded) for cpu_ready and score it.
  task automatic applyStimulus(input logic rw, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expHit,
                               input int expCycles);
    cpuExp_t e;
    int      n;
    e.rdata  = expRdata;
    e.hit    = expHit;
    e.cycles = expCycles;
    cpuQ.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    checkOutput("cpu_ready_after_accept", bus.cpu_ready, 1'b0);
    n = 1;
    while (!bus.cpu_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("cpu_ready_timeout", bus.cpu_ready, 1'b1);
    e = cpuQ.pop_front();
    checkOutput("cpu_rdata", bus.cpu_rdata, e.rdata);
    checkOutput("cpu_hit", bus.cpu_hit, e.hit);
    checkOutput("latency", n, e.cycles);
  endtask

  // Memory model: serves block requests after memWait idle cycles with a one-cycle mem_ready.
  initial begin
    memExp_t me;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    memWaitLeft   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (!bus.mem_req) begin
        memWaitLeft = memWait;
      end else if (memEnable) begin
        if (memWaitLeft > 0) begin
          memWaitLeft--;
        end else begin
          if (memQ.size() == 0) begin
            checkOutput("mem_unexpected_req", bus.mem_req, 1'b0);
          end else begin
            me = memQ.pop_front();
            checkOutput("mem_rw", bus.mem_rw, me.rw);
            checkOutput("mem_addr", bus.mem_addr, me.addr);
            if (me.rw) checkOutput("mem_wdata", bus.mem_wdata, me.wdata);
          end
          if (bus.mem_rw) memArr[bus.mem_addr[9:4]] = bus.mem_wdata;
          else            bus.mem_rdata = memArr[bus.mem_addr[9:4]];
          bus.mem_ready = 1'b1;
          memWaitLeft   = memWait;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    checks        = 0;
    failures      = 0;
    memWait       = 0;
    memEnable     = 1'b1;
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (b == 0) memArr[b][w*32 +: 32] = 32'h11111111 * w;
        else        memArr[b][w*32 +: 32] = {8'hC0, 8'(b), 16'(w)};
      end
    end

    #2 reset = 1'b1;
    #1;
    checkOutput("rst_cpu_ready", bus.cpu_ready, 1'b0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("rst_cpu_hit", bus.cpu_hit, 1'b0);
    checkOutput("rst_mem_req", bus.mem_req, 1'b0);
    checkOutput("rst_mem_rw", bus.mem_rw, 1'b0);
    checkOutput("rst_mem_addr", bus.mem_addr, 10'h0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 128'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Cold read, hit read, write hit, then dirty eviction.
    pushMem(1'b0, 10'h000, '0);
    applyStimulus(1'b0, 10'h000, 32'h0, 32'h00000000, 1'b0, 4);
    applyStimulus(1'b0, 10'h004, 32'h0, 32'h11111111, 1'b1, 2);
    applyStimulus(1'b1, 10'h008, 32'hDEADBEEF, 32'h11111111, 1'b1, 2);
    pushMem(1'b1, 10'h000, 128'h33333333_DEADBEEF_11111111_00000000);
    pushMem(1'b0, 10'h100, '0);
    applyStimulus(1'b0, 10'h108, 32'h0, 32'hC0100002, 1'b0, 6);
    pushMem(1'b0, 10'h010, '0);
    applyStimulus(1'b0, 10'h010, 32'h0, 32'hC0010000, 1'b0, 4);
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("hit_cnt_1to4", hitCnt, 16'd2);
    checkOutput("miss_cnt_1to4", missCnt, 16'd3);
`endif
    applyStimulus(1'b0, 10'h104, 32'h0, 32'hC0100001, 1'b1, 2);

    // Slow memory: clean then dirty miss on line 1.
    memWait = 2;
    pushMem(1'b0, 10'h030, '0);
    applyStimulus(1'b0, 10'h034, 32'h0, 32'hC0030001, 1'b0, 6);
    applyStimulus(1'b1, 10'h038, 32'h12345678, 32'hC0030001, 1'b1, 2);
    pushMem(1'b1, 10'h030, 128'hC0030003_12345678_C0030001_C0030000);
    pushMem(1'b0, 10'h010, '0);
    applyStimulus(1'b0, 10'h018, 32'h0, 32'hC0010002, 1'b0, 10);
    memWait = 0;
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("hit_cnt_mid", hitCnt, 16'd4);
    checkOutput("miss_cnt_mid", missCnt, 16'd5);
`endif

    // Reset while a refill is outstanding.
    memEnable     = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 10'h000;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("alloc_mem_req", bus.mem_req, 1'b1);
    checkOutput("alloc_mem_rw", bus.mem_rw, 1'b0);
    checkOutput("alloc_mem_addr", bus.mem_addr, 10'h000);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_mem_req", bus.mem_req, 1'b0);
    checkOutput("midrst_cpu_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("midrst_cpu_hit", bus.cpu_hit, 1'b0);
    checkOutput("midrst_mem_addr", bus.mem_addr, 10'h0);
    checkOutput("midrst_mem_wdata", bus.mem_wdata, 128'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    memEnable = 1'b1;
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("hit_cnt_rst", hitCnt, 16'd0);
    checkOutput("miss_cnt_rst", missCnt, 16'd0);
`endif

    // Valid bits were cleared, so this misses and refills the written-back block.
    pushMem(1'b0, 10'h000, '0);
    applyStimulus(1'b0, 10'h004, 32'h0, 32'h11111111, 1'b0, 4);
    applyStimulus(1'b0, 10'h008, 32'h0, 32'hDEADBEEF, 1'b1, 2);
`ifdef CACHE_CTRL_STATS_EN
    checkOutput("hit_cnt_end", hitCnt, 16'd1);
    checkOutput("miss_cnt_end", missCnt, 16'd1);
`endif
    checkOutput("mem_queue_left", memQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
